// File: rtl/layer_featuremap_pkg.sv
// rtl/layer_featuremap_pkg.sv - shared constants and FSM states for the layer-4 feature-map stream blocks
//
// Purpose: constants shared by the source-side streamer and the sink-side
// collector, plus the frame-sequencing state enum both of them use.
//   CHANNELS      channels per packed pixel (32-bit float each)
//   DATA_IN_WIDTH packed pixel width, channel k in bits [32k+31:32k]
//   IMG_SIZE      default frame width/height in pixels
//   ADDR_WIDTH    default SRAM address width (2^ADDR_WIDTH >= IMG_SIZE^2)
package layer_featuremap_pkg;

  localparam int CHANNELS      = 32;
  localparam int DATA_IN_WIDTH = CHANNELS * 32;
  localparam int IMG_SIZE      = 104;
  localparam int ADDR_WIDTH    = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_e;

endpackage

// File: rtl/layer_4_featuremap_streamer_if.sv
// rtl/layer_4_featuremap_streamer_if.sv - control, SRAM read and pixel stream bundle of the streamer
//
// Purpose: groups every non-clock/reset signal of the streamer.
//   start/pause   in   frame request, read stall
//   busy/done     out  frame in progress, end-of-frame pulse
//   mem_rd_en     out  SRAM read strobe
//   mem_addr      out  SRAM linear raster address
//   mem_rd_data   in   SRAM read data, valid the cycle after mem_rd_en
//   data_out      out  packed pixel to the featuremap
//   valid_out     out  data_out qualifier (no backpressure)
//   eol/eof       out  last pixel of row / frame, qualified by valid_out
// Modport master is the streamer's view, slave is the environment's view.
interface layer_4_featuremap_streamer_if #(
  parameter int DATA_W = layer_featuremap_pkg::DATA_IN_WIDTH,
  parameter int ADDR_W = layer_featuremap_pkg::ADDR_WIDTH
);

  logic              start;
  logic              pause;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              eol;
  logic              eof;

  modport master (
    input  start, pause, mem_rd_data,
    output busy, done, mem_rd_en, mem_addr, data_out, valid_out, eol, eof
  );

  modport slave (
    output start, pause, mem_rd_data,
    input  busy, done, mem_rd_en, mem_addr, data_out, valid_out, eol, eof
  );

endinterface

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - column/row/linear-address raster counter with end-of-line/frame flags
//
// Purpose: walks an IMG_SIZE x IMG_SIZE frame in raster order.
//   clk, rst_n  clock, asynchronous active-low reset
//   en          advance one pixel
//   clr         return to pixel 0 (wins over en)
//   addr        linear index row*IMG_SIZE+col of the current pixel
//   eol         current pixel is the last of its row
//   eof         current pixel is the last of the frame
module raster_counter #(
  parameter int IMG_SIZE   = layer_featuremap_pkg::IMG_SIZE,
  parameter int ADDR_WIDTH = layer_featuremap_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  eol,
  output logic                  eof
);

  localparam int CW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

  logic [CW-1:0] col;
  logic [CW-1:0] row;

  assign eol = (col == LAST);
  assign eof = eol && (row == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clr) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (en) begin
      if (eof) begin
        // The linear address is wrapped explicitly: IMG_SIZE^2 is generally
        // not a power of two, so natural overflow would not land on 0.
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else begin
        addr <= addr + ADDR_WIDTH'(1);
        if (eol) begin
          col <= '0;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/layer_4_featuremap_streamer.sv
// rtl/layer_4_featuremap_streamer.sv - reads one feature-map frame from SRAM and streams it in raster order
//
// Purpose: frame sequencing (IDLE/RUN/DRAIN), SRAM address generation with
// pause, and a two-stage read pipeline that tags each pixel with eol/eof.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset; discards any in-flight reads
//   bus    layer_4_featuremap_streamer_if master: start/pause/busy/done,
//          mem_rd_en/mem_addr/mem_rd_data, data_out/valid_out/eol/eof
module layer_4_featuremap_streamer #(
  parameter int DATA_IN_WIDTH = layer_featuremap_pkg::DATA_IN_WIDTH,
  parameter int IMG_SIZE      = layer_featuremap_pkg::IMG_SIZE,
  parameter int ADDR_WIDTH    = layer_featuremap_pkg::ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  layer_4_featuremap_streamer_if.master bus
);

  import layer_featuremap_pkg::*;

  stream_state_e state_q;
  stream_state_e state_d;

  logic                  rd_en;
  logic                  cnt_clr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  tag_eol;
  logic                  tag_eof;

  // Stage 1: read issued last cycle, SRAM data arrives this cycle.
  logic s1_valid;
  logic s1_eol;
  logic s1_eof;

  // Stage 2: registered outputs to the featuremap.
  logic [DATA_IN_WIDTH-1:0] data_q;
  logic                     valid_q;
  logic                     eol_q;
  logic                     eof_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (bus.start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Combinational so pause stalls the read in the very cycle it rises.
        rd_en = !bus.pause;
        if (rd_en && tag_eof) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // eof_q is the eof beat on the output; leave once it has been shown.
        if (eof_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  raster_counter #(
    .IMG_SIZE   (IMG_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_raster (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rd_en),
    .clr   (cnt_clr),
    .addr  (rd_addr),
    .eol   (tag_eol),
    .eof   (tag_eof)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else begin
      s1_valid <= rd_en;
      s1_eol   <= rd_en && tag_eol;
      s1_eof   <= rd_en && tag_eof;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      valid_q <= s1_valid;
      eol_q   <= s1_eol;
      eof_q   <= s1_eof;
      // Only capture real read data so data_out holds across gaps.
      if (s1_valid) begin
        data_q <= bus.mem_rd_data;
      end
    end
  end

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = rd_addr;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.eol       = eol_q;
  assign bus.eof       = eof_q;
  assign bus.done      = eof_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_layer_4_featuremap_streamer.sv
// tb/tb_layer_4_featuremap_streamer.sv - self-checking bench for the layer-4 feature-map streamer
module tb_layer_4_featuremap_streamer;

  localparam int DW = 1024;
  localparam int SW = 4;
  localparam int LW = 104;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s;
  logic rst_l;
  logic start;
  logic pause;
  int   sel;
  int   scen;
  int   cyc;

  int vectors     = 0;
  int miscompares = 0;

  layer_4_featuremap_streamer_if #(.DATA_W(DW), .ADDR_W(4))  bus_s ();
  layer_4_featuremap_streamer_if #(.DATA_W(DW), .ADDR_W(14)) bus_l ();

  assign bus_s.start = (sel == 0) && start;
  assign bus_s.pause = (sel == 0) && pause;
  assign bus_l.start = (sel == 1) && start;
  assign bus_l.pause = (sel == 1) && pause;

  layer_4_featuremap_streamer #(.DATA_IN_WIDTH(DW), .IMG_SIZE(SW), .ADDR_WIDTH(4)) dut_s (
    .clk   (clk),
    .rst_n (rst_s),
    .bus   (bus_s)
  );

  layer_4_featuremap_streamer #(.DATA_IN_WIDTH(DW), .IMG_SIZE(LW), .ADDR_WIDTH(14)) dut_l (
    .clk   (clk),
    .rst_n (rst_l),
    .bus   (bus_l)
  );

  // SRAM contents: small frame word n = n, large frame a per-channel hash of n.
  function automatic logic [DW-1:0] word_of(input int s, input int a);
    logic [DW-1:0] w;
    w = '0;
    if (s == 0) begin
      w[31:0] = 32'(a);
    end else begin
      for (int k = 0; k < 32; k++) begin
        w[32*k +: 32] = (32'(a) * 32'h9E37_79B1) ^ 32'(k);
      end
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (bus_s.mem_rd_en) bus_s.mem_rd_data <= word_of(0, int'(bus_s.mem_addr));
    if (bus_l.mem_rd_en) bus_l.mem_rd_data <= word_of(1, int'(bus_l.mem_addr));
  end

  logic          o_rd, o_valid, o_eol, o_eof, o_busy, o_done;
  int            o_addr;
  logic [DW-1:0] o_data;

  always_comb begin
    if (sel == 0) begin
      o_rd = bus_s.mem_rd_en; o_addr = int'(bus_s.mem_addr); o_data = bus_s.data_out;
      o_valid = bus_s.valid_out; o_eol = bus_s.eol; o_eof = bus_s.eof;
      o_busy = bus_s.busy; o_done = bus_s.done;
    end else begin
      o_rd = bus_l.mem_rd_en; o_addr = int'(bus_l.mem_addr); o_data = bus_l.data_out;
      o_valid = bus_l.valid_out; o_eol = bus_l.eol; o_eof = bus_l.eof;
      o_busy = bus_l.busy; o_done = bus_l.done;
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d scen=%0d got=%0h exp=%0h", nm, cyc, scen, got, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d scen=%0d got[127:0]=%0h exp[127:0]=%0h", nm, cyc, scen,
               got[127:0], exp[127:0]);
    end
  endtask

  // Reference model: frame = sequence of pixel reads, one per unpaused RUN
  // cycle; each read reappears as a beat two cycles later.
  bit            m_busy  = 1'b0;
  bit            m_issue = 1'b0;
  int            m_next  = 0;
  int            pipe[$] = '{-1, -1};
  logic [DW-1:0] m_last [2] = '{'0, '0};
  int            n_beats = 0, n_eol = 0, n_eof = 0, n_done = 0;
  bit            big_done = 1'b0;

  always @(negedge clk) begin : cmp
    int w, n, beat;
    bit rst_now, e_rd, e_valid, e_eol, e_eof;
    w       = (sel == 0) ? SW : LW;
    n       = w * w;
    rst_now = (sel == 0) ? rst_s : rst_l;
    if (!rst_now) begin
      chk("rst_mem_rd_en", o_rd, 0);
      chk("rst_mem_addr", o_addr, 0);
      chk_data("rst_data_out", o_data, '0);
      chk("rst_valid_out", o_valid, 0);
      chk("rst_eol", o_eol, 0);
      chk("rst_eof", o_eof, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      m_busy = 1'b0; m_issue = 1'b0; m_next = 0;
      pipe = '{-1, -1};
      m_last[sel] = '0;
    end else begin
      e_rd    = m_issue && !pause;
      beat    = pipe[0];
      e_valid = (beat >= 0);
      e_eol   = e_valid && (beat % w == w - 1);
      e_eof   = (beat == n - 1);
      if (e_valid) m_last[sel] = word_of(sel, beat);

      chk("mem_rd_en", o_rd, e_rd);
      if (m_issue) chk("mem_addr", o_addr, m_next);
      chk("valid_out", o_valid, e_valid);
      chk("eol", o_eol, e_eol);
      chk("eof", o_eof, e_eof);
      chk("done", o_done, e_eof);
      chk("busy", o_busy, m_busy);
      chk_data("data_out", o_data, m_last[sel]);

      if (o_valid) n_beats++;
      if (o_valid && o_eol) n_eol++;
      if (o_valid && o_eof) n_eof++;
      if (o_done) n_done++;
      if (o_done && sel == 1) big_done = 1'b1;

      // Hand-computed expectations for the directed small-frame cases.
      case (scen)
        1: begin
          if (cyc == 2)  chk("s1_no_beat_c2", o_valid, 0);
          if (cyc == 3)  begin chk("s1_beat0_c3", o_valid, 1); chk("s1_beat0_val", o_data[31:0], 0); end
          if (cyc == 6)  chk("s1_eol_beat3", o_eol, 1);
          if (cyc == 18) begin chk("s1_eof_c18", o_eof, 1); chk("s1_done_c18", o_done, 1);
                               chk("s1_beat15_val", o_data[31:0], 15); end
          if (cyc == 19) begin chk("s1_busy_low_c19", o_busy, 0); chk("s1_beats", n_beats, 16);
                               chk("s1_eol_cnt", n_eol, 4); chk("s1_eof_cnt", n_eof, 1); end
          if (cyc == 21) chk("s1_f2_no_beat_c21", o_valid, 0);
          if (cyc == 22) begin chk("s1_f2_beat0_c22", o_valid, 1); chk("s1_f2_beat0_val", o_data[31:0], 0); end
        end
        2: begin
          if (cyc >= 5 && cyc <= 7) begin chk("s2_addr_hold", o_addr, 4); chk("s2_rd_paused", o_rd, 0); end
          if (cyc == 8)  begin chk("s2_rd_resume", o_rd, 1); chk("s2_addr_resume", o_addr, 4); end
          if (cyc >= 7 && cyc <= 9) chk("s2_gap", o_valid, 0);
          if (cyc == 10) begin chk("s2_beat4_c10", o_valid, 1); chk("s2_beat4_val", o_data[31:0], 4); end
          if (cyc == 21) begin chk("s2_done_c21", o_done, 1); chk("s2_beat15_val", o_data[31:0], 15); end
          if (cyc == 22) begin chk("s2_beats", n_beats, 16); chk("s2_done_cnt", n_done, 1);
                               chk("s2_busy_low", o_busy, 0); end
        end
        3: begin
          if (cyc == 12) begin chk("s3_beats_before_rst", n_beats, 5); chk("s3_no_eof", n_eof, 0);
                               chk("s3_no_done", n_done, 0); chk("s3_idle", o_busy, 0); end
        end
        4: begin
          if (cyc == 3)  begin chk("s4_beat0_c3", o_valid, 1); chk("s4_beat0_val", o_data[31:0], 0); end
          if (cyc == 18) chk("s4_done_c18", o_done, 1);
          if (cyc == 19) chk("s4_beats", n_beats, 16);
        end
        6: begin
          chk("big_done_seen", big_done, 1);
          chk("big_beats", n_beats, LW * LW);
          chk("big_eol_cnt", n_eol, LW);
          chk("big_eof_cnt", n_eof, 1);
          chk("big_done_cnt", n_done, 1);
        end
        default: ;
      endcase

      void'(pipe.pop_front());
      pipe.push_back(e_rd ? m_next : -1);
      if (e_rd) begin
        m_next++;
        if (m_next == n) m_issue = 1'b0;
      end
      if (e_eof) begin
        m_busy = 1'b0;
      end else if (!m_busy && start) begin
        m_busy = 1'b1; m_issue = 1'b1; m_next = 0;
        n_beats = 0; n_eol = 0; n_eof = 0; n_done = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst_s = 1'b0; rst_l = 1'b0; start = 1'b0; pause = 1'b0;
    sel = 0; scen = 0; cyc = 0;
    repeat (3) tick();
    rst_s = 1'b1; rst_l = 1'b1;
    repeat (3) tick();

    // Plain frame, then a second start in the cycle busy falls.
    scen = 1; cyc = 0; start = 1'b1;
    repeat (45) begin
      tick();
      start = (cyc == 19);
    end

    // Pause for cycles 5..7 and ignored starts at cycles 4 and 10.
    scen = 2; cyc = 0; start = 1'b1;
    repeat (26) begin
      tick();
      start = (cyc == 4 || cyc == 10);
      pause = (cyc >= 5 && cyc <= 7);
    end

    // Reset for one cycle mid-frame.
    scen = 3; cyc = 0; start = 1'b1;
    repeat (14) begin
      tick();
      start = 1'b0;
      rst_s = !(cyc == 8);
    end

    // Full frame after the mid-frame reset.
    scen = 4; cyc = 0; start = 1'b1;
    repeat (22) begin
      tick();
      start = 1'b0;
    end

    // Default-size frame under random pause at roughly 30% density.
    sel = 1;
    tick();
    scen = 5; cyc = 0; start = 1'b1;
    pause = ($urandom_range(99) < 30);
    while (!big_done && cyc < 20000) begin
      tick();
      start = 1'b0;
      pause = ($urandom_range(99) < 30);
    end
    repeat (5) begin
      tick();
      pause = ($urandom_range(99) < 30);
    end
    scen = 6;
    tick();
    scen = 7;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
